simple_nios_lab_onchip_pipe: RTL
================================

// Module: simple_nios_lab_onchip_pipe
// PURPOSE
//  Parametrised Avalon-MM on-chip RAM slave for the Nios system; successor of the fixed 2048x32 single-port RAM.
//  - Adds configurable width/depth, a 1- or 2-cycle pipelined read with readdatavalid, and waitrequest back-pressure.
//  - Adds an optional zero-fill of the whole array after reset.
//  - Sits on the system interconnect as the instruction/data memory of the Nios core.
// PARAMETERS
//  DATA_W          32    data width in bits; multiple of 8
//  ADDR_W          11    word-address width
//  DEPTH           2048  implemented words; <= 2**ADDR_W
//  READ_LATENCY    1     1 or 2 clk from read accept to readdatavalid; any other value is a compile-time error
//  CLEAR_ON_RESET  0     1: zero-fill every word after reset before accepting traffic
//  INIT_FILE       "simple_nios_lab_onchip.hex"  memory init file; unused for content if CLEAR_ON_RESET=1
// PORTS
//  clk            in   1          system clock
//  reset          in   1          synchronous, active-high reset
//  address        in   ADDR_W     word address
//  byteenable     in   DATA_W/8   write byte lanes
//  chipselect     in   1          slave select
//  read           in   1          read request
//  write          in   1          write request
//  writedata      in   DATA_W     write data
//  clken          in   1          clock enable; 0 freezes the block
//  reset_req      in   1          pending-reset request; 1 freezes the block
//  readdata       out  DATA_W     read data; valid only with readdatavalid
//  readdatavalid  out  1          one pulse per accepted read
//  waitrequest    out  1          1 = command not accepted this cycle
//  parity_err     out  1          read-data parity error, qualified by readdatavalid
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high. All outputs are 0 during and after reset, except waitrequest.
//    - waitrequest=1 in reset; after reset it is 0, or 1 for the duration of CLEAR if CLEAR_ON_RESET=1.
//  - FSM states CLEAR and RUN.
//    - Reset -> CLEAR if CLEAR_ON_RESET=1, else RUN.
//    - CLEAR writes 0 to word 0..DEPTH-1, one word per enabled cycle (all byte lanes), with waitrequest=1.
//    - CLEAR -> RUN after the word DEPTH-1 write; takes exactly DEPTH enabled cycles.
//  - stall = ~clken | reset_req. While stalled:
//    - waitrequest=1; no command accepted; FSM, CLEAR counter and read pipeline hold.
//    - readdatavalid is forced 0. A held read returns its pulse once the stall ends; none is lost or duplicated.
//  - Accept: RUN & ~stall & chipselect & (read|write).
//  - Write: byte lanes with byteenable=1 are updated at the accepting edge.
//  - Read: readdata/readdatavalid appear READ_LATENCY enabled cycles after accept.
//    - Back-to-back reads: one per cycle, fully pipelined.
//  - Read and write in the same accept cycle: the write is performed, the read is dropped, no readdatavalid.
//  - Read-during-write to the same word on consecutive cycles: the read returns the newly written data (write completes first).
//  - address >= DEPTH: write ignored; read returns 0 with a normal readdatavalid and parity_err=0.
//  - Reset mid-CLEAR or mid-read: pipeline flushed; no readdatavalid issued for in-flight reads; CLEAR restarts at word 0.
// CONFIGURATION
//  - ONCHIP_PARITY_EN defined:
//    - One even-parity bit per byte is stored alongside data and written per enabled lane.
//    - Parity is checked on read; parity_err=1 with readdatavalid if any lane mismatches.
//    - CLEAR writes matching parity (0).
//  - ONCHIP_PARITY_EN undefined: no parity storage; parity_err tied 0.
// STRUCTURE
//  - Package simple_nios_onchip_pkg: READ_LATENCY limits, FSM state enum (ST_CLEAR, ST_RUN), parity-function macro/constant for bytes per word.
//  - Sub-module onchip_ram_core: inferred single-port byte-enable RAM, DEPTH x (DATA_W[+DATA_W/8]), 1-cycle registered read.
//  - Top: FSM, CLEAR counter, accept logic, READ_LATENCY-1 extra output stage, valid shift register.
// TESTING
//  - Reset, CLEAR_ON_RESET=1, DEPTH=16 -> waitrequest=1 for exactly 16 cycles after reset; every word then reads 0x00000000.
//  - Write 0xDEADBEEF to addr 5 with byteenable=4'b0101, after prior 0x11223344 -> read addr 5 gives 0x11AD33EF.
//  - READ_LATENCY=2, reads of addr 0,1,2 back-to-back -> readdatavalid high on cycles +2,+3,+4 with data in order.
//  - clken=0 for 3 cycles, one cycle after a read accept -> readdatavalid delayed 3 cycles, single pulse, correct data.
//  - DEPTH=1000, read addr 1500 -> readdata=0, readdatavalid=1; write addr 1500 leaves words 0..999 unchanged.
//  - ONCHIP_PARITY_EN: force the stored parity bit of lane 2 to flip -> the read gives parity_err=1 with readdatavalid; an unflipped word gives 0.

Source files
------------

// File: rtl/simple_nios_onchip_pkg.sv
// Shared types and helpers for the pipelined on-chip RAM slave.
// ONCHIP_PARITY_EN selects 9-bit storage lanes (byte + even-parity bit).
package simple_nios_onchip_pkg;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

`ifdef ONCHIP_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif

  function automatic int bytes_per_word(input int w);
    return w / 8;
  endfunction

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Single-port RAM with per-lane write enables and a 1-cycle registered read.
// Holds its read register whenever en is low.
module onchip_ram_core #(
  parameter int DEPTH  = 2048,
  parameter int AW     = 11,
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic                    re,
  input  logic [AW-1:0]           addr,
  input  logic [LANES-1:0]        be,
  input  logic [LANES*LANE_W-1:0] wdata,
  output logic [LANES*LANE_W-1:0] q
);

  logic [LANES*LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
      if (re) q <= mem[addr];
    end
  end

endmodule

// File: rtl/simple_nios_lab_onchip_pipe.sv
// Avalon-MM on-chip RAM slave: optional zero-fill after reset, 1/2-cycle pipelined read.
// Define ONCHIP_PARITY_EN to store and check one even-parity bit per byte.
module simple_nios_lab_onchip_pipe
  import simple_nios_onchip_pkg::*;
#(
  parameter int    DATA_W         = 32,
  parameter int    ADDR_W         = 11,
  parameter int    DEPTH          = 2048,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = "simple_nios_lab_onchip.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  input  logic                reset_req,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                parity_err
);

  localparam int LANES  = bytes_per_word(DATA_W);
  localparam int WORD_W = LANES * LANE_W;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [RAM_AW-1:0] LAST_WORD = RAM_AW'(DEPTH - 1);

  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  // Without zero-fill the power-up contents come from INIT_FILE via the RAM build flow.
  if (CLEAR_ON_RESET == 0 && INIT_FILE == "") begin : g_no_init
    $error("INIT_FILE is required when CLEAR_ON_RESET is 0");
  end

  state_t            state;
  logic [RAM_AW-1:0] clr_addr;
  logic              stall, in_range, accept, wr_acc, rd_acc, clearing;
  logic              ram_en, ram_we, ram_re;
  logic [RAM_AW-1:0] ram_addr;
  logic [LANES-1:0]  ram_be;
  logic [WORD_W-1:0] wword, ram_wdata, rword;

  assign stall       = ~clken | reset_req;
  assign in_range    = {1'b0, address} < DEPTH_L;
  assign accept      = (state == ST_RUN) & ~stall & ~reset & chipselect & (read | write);
  assign wr_acc      = accept & write;
  assign rd_acc      = accept & read & ~write;
  assign clearing    = (state == ST_CLEAR) & ~stall & ~reset;
  assign waitrequest = reset | stall | (state != ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_addr <= '0;
    end else if (clearing) begin
      if (clr_addr == LAST_WORD) state <= ST_RUN;
      else                       clr_addr <= clr_addr + 1'b1;
    end
  end

  always_comb begin
    wword = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef ONCHIP_PARITY_EN
      wword[i*LANE_W +: LANE_W] = {byte_parity(writedata[i*8 +: 8]), writedata[i*8 +: 8]};
`else
      wword[i*LANE_W +: LANE_W] = writedata[i*8 +: 8];
`endif
    end
  end

  // Zero data with zero parity is a consistent word, so CLEAR writes all-zero lanes.
  assign ram_en    = ~stall & ~reset;
  assign ram_we    = clearing | (wr_acc & in_range);
  assign ram_re    = rd_acc & in_range;
  assign ram_addr  = clearing ? clr_addr : address[RAM_AW-1:0];
  assign ram_be    = clearing ? '1 : byteenable;
  assign ram_wdata = clearing ? '0 : wword;

  onchip_ram_core #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW),
    .LANES (LANES),
    .LANE_W(LANE_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .be   (ram_be),
    .wdata(ram_wdata),
    .q    (rword)
  );

  // ---- stage p0: RAM read register, valid and out-of-range tag ----
  logic              vld_p0, oor_p0, perr_p0;
  logic [DATA_W-1:0] rdata_p0;

  always_ff @(posedge clk) begin
    if (reset)       vld_p0 <= 1'b0;
    else if (!stall) vld_p0 <= rd_acc;
  end

  always_ff @(posedge clk) begin
    if (!stall) oor_p0 <= ~in_range;
  end

  always_comb begin
    rdata_p0 = '0;
    perr_p0  = 1'b0;
    if (!oor_p0) begin
      for (int i = 0; i < LANES; i++) begin
        rdata_p0[i*8 +: 8] = rword[i*LANE_W +: 8];
`ifdef ONCHIP_PARITY_EN
        perr_p0 = perr_p0 | (^rword[i*LANE_W +: LANE_W]);
`endif
      end
    end
  end

  // ---- stage p1: optional extra output register ----
  logic              vld_out, perr_out;
  logic [DATA_W-1:0] data_out;

  if (READ_LATENCY == 2) begin : g_rl2
    logic              vld_p1, perr_p1;
    logic [DATA_W-1:0] rdata_p1;

    always_ff @(posedge clk) begin
      if (reset)       vld_p1 <= 1'b0;
      else if (!stall) vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
      if (!stall) begin
        rdata_p1 <= rdata_p0;
        perr_p1  <= perr_p0;
      end
    end

    assign vld_out  = vld_p1;
    assign data_out = rdata_p1;
    assign perr_out = perr_p1;
  end else begin : g_rl1
    assign vld_out  = vld_p0;
    assign data_out = rdata_p0;
    assign perr_out = perr_p0;
  end

  // A held read keeps its valid bit; it is only masked while stalled.
  assign readdatavalid = vld_out & ~stall & ~reset;
  assign readdata      = readdatavalid ? data_out : '0;
  assign parity_err    = readdatavalid & perr_out;

endmodule
